demux_1x2_stream: RTL and testbench
===================================

// Module: demux_1x2_stream
// PURPOSE
//  Registered 1-to-2 stream demultiplexer; the routing counterpart of the 2x1 mux datapath.
//  Steers each input beat to output 0 or 1 per its sel bit, with valid/ready on all ports.
//  One-entry holding slot per output, so a stalled output never blocks the other output.
//  Per-output saturating beat counters for bring-up and debug.
// PARAMETERS
//  DW     8   data width in bits
//  CNTW   16  width of per-output beat counters
// PORTS
//  clk        in   1     single clock; all state updates on rising edge
//  rst        in   1     synchronous, active-high reset
//  in_valid   in   1     input beat present
//  in_sel     in   1     destination: 0 -> out0, 1 -> out1; sampled with in_data
//  in_data    in   DW    input payload
//  in_ready   out  1     input beat accepted this cycle when in_valid && in_ready
//  out0_valid out  1     slot 0 holds a beat
//  out0_data  out  DW    slot 0 payload
//  out0_ready in   1     downstream 0 accepts
//  out1_valid out  1     slot 1 holds a beat
//  out1_data  out  DW    slot 1 payload
//  out1_ready in   1     downstream 1 accepts
//  cnt0       out  CNTW  beats delivered on out0 (saturates at all-ones)
//  cnt1       out  CNTW  beats delivered on out1 (saturates at all-ones)
// BEHAVIOUR
//  - Reset (rst=1 at edge): outN_valid=0, outN_data=0, cnt0=cnt1=0; in_ready=0 while rst=1.
//  - Slot N free(N) = !outN_valid || outN_ready. in_ready = !rst && free(in_sel), combinational.
//  - Accept (in_valid && in_ready): beat loads slot in_sel next edge; outN_valid=1. Latency 1 cycle.
//  - Drain: outN_valid && outN_ready clears slot N unless refilled the same edge.
//  - Simultaneous drain + accept to same slot: slot reloads; outN_valid stays 1; full throughput.
//  - Accept to slot A while slot B stalled: allowed; B contents, valid unchanged.
//  - outN_data holds value while outN_valid && !outN_ready (AXI-style stability); in_sel and
//    in_data need not be stable before acceptance.
//  - No reordering within a channel; beats to different channels carry no mutual ordering.
//  - cntN increments on each outN handshake; holds at 2^CNTW-1.
//  - No FSM beyond per-slot EMPTY/FULL: EMPTY->FULL on load; FULL->EMPTY on drain w/o load.
//  - Reset mid-operation: held beats discarded, counters cleared; no handshake during rst.
//  - X on in_sel while in_valid=1 is a protocol error; bench asserts against it.
// STRUCTURE
//  - Package demux_pkg: localparam CH_OUT0=1'b0, CH_OUT1=1'b1; default DW, CNTW.
//  - Sub-module demux_out_slot (one per output): one-entry register slice plus saturating
//    counter; ports clk, rst, load, load_data, valid, data, ready, free, cnt.
//  - Top: in_sel decode into load strobes, in_ready mux of the two free signals.
// TESTING
//  1 Reset: rst=1 for 2 cycles, in_valid=1 -> in_ready=0, out*_valid=0, cnt*=0.
//  2 Route: beats 0xA5 sel=0, 0x3C sel=1, ready=1 -> out0 0xA5 at +1 cycle, out1 0x3C next; cnt0=cnt1=1.
//  3 Back-to-back: 16 beats sel=0, out0_ready=1 -> in_ready stays 1, 16 beats in order, cnt0=16.
//  4 Isolation: out0_ready=0 holding 0x11; send sel=1 beat 0x22 -> accepted, out1 gets 0x22;
//    next sel=0 beat stalls (in_ready=0) until out0_ready=1.
//  5 Saturation: CNTW=4, 20 beats to out1 -> cnt1=15 and holds.
//  6 Mid-op reset: both slots full, rst=1 one cycle -> valids 0, counters 0; next beat routes normally.

Source files
------------

// File: rtl/demux_1x2_stream_pkg.sv
// demux_pkg: channel codes, default widths and slot state type shared by the 1x2 stream demux
package demux_pkg;
  localparam logic CH_OUT0 = 1'b0;
  localparam logic CH_OUT1 = 1'b1;
  localparam int DEF_DW = 8;
  localparam int DEF_CNTW = 16;
  typedef enum logic {EMPTY, FULL} slot_state_e;
endpackage

// File: rtl/demux_1x2_stream_if.sv
// demux_1x2_stream_if: stream bundle (in_valid/in_sel/in_data/in_ready in, outN_valid/data/ready out, cnt0/cnt1 debug); master=source/sinks, slave=demux
interface demux_1x2_stream_if #(
  parameter int DW = 8,
  parameter int CNTW = 16
);
  logic in_valid;
  logic in_sel;
  logic [DW-1:0] in_data;
  logic in_ready;
  logic out0_valid;
  logic [DW-1:0] out0_data;
  logic out0_ready;
  logic out1_valid;
  logic [DW-1:0] out1_data;
  logic out1_ready;
  logic [CNTW-1:0] cnt0;
  logic [CNTW-1:0] cnt1;
  modport master (
    output in_valid, in_sel, in_data, out0_ready, out1_ready,
    input in_ready, out0_valid, out0_data, out1_valid, out1_data, cnt0, cnt1
  );
  modport slave (
    input in_valid, in_sel, in_data, out0_ready, out1_ready,
    output in_ready, out0_valid, out0_data, out1_valid, out1_data, cnt0, cnt1
  );
endinterface

// File: rtl/demux_out_slot.sv
// demux_out_slot: one-entry output register slice with saturating beat counter (ports clk, rst, load, load_data, valid, data, ready, free, cnt)
module demux_out_slot import demux_pkg::*; #(
  parameter int DW = DEF_DW,
  parameter int CNTW = DEF_CNTW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [DW-1:0]   load_data,
  output logic            valid,
  output logic [DW-1:0]   data,
  input  logic            ready,
  output logic            free,
  output logic [CNTW-1:0] cnt
);
  slot_state_e r_state, w_state_nxt;
  logic [DW-1:0] r_data;
  logic [CNTW-1:0] r_cnt;
  logic w_drain;
  assign valid = r_state == FULL;
  assign w_drain = valid && ready;
  assign free = !valid || ready;
  assign data = r_data;
  assign cnt = r_cnt;
  always_comb begin
    w_state_nxt = load ? FULL : w_drain ? EMPTY : r_state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= EMPTY;
      r_data <= '0;
      r_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (load) r_data <= load_data;
      if (w_drain && !(&r_cnt)) r_cnt <= r_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/demux_1x2_stream.sv
// demux_1x2_stream: registered 1-to-2 stream demux (clk, rst, bus slave: in stream -> out0/out1 streams, cnt0/cnt1 beat counters)
module demux_1x2_stream import demux_pkg::*; #(
  parameter int DW = DEF_DW,
  parameter int CNTW = DEF_CNTW
) (
  input logic clk,
  input logic rst,
  demux_1x2_stream_if.slave bus
);
  logic w_free0, w_free1, w_accept;
  assign bus.in_ready = !rst && (bus.in_sel == CH_OUT1 ? w_free1 : w_free0);
  assign w_accept = bus.in_valid && bus.in_ready;
  demux_out_slot #(.DW(DW), .CNTW(CNTW)) u_slot0 (
    .clk       (clk),
    .rst       (rst),
    .load      (w_accept && bus.in_sel == CH_OUT0),
    .load_data (bus.in_data),
    .valid     (bus.out0_valid),
    .data      (bus.out0_data),
    .ready     (bus.out0_ready),
    .free      (w_free0),
    .cnt       (bus.cnt0)
  );
  demux_out_slot #(.DW(DW), .CNTW(CNTW)) u_slot1 (
    .clk       (clk),
    .rst       (rst),
    .load      (w_accept && bus.in_sel == CH_OUT1),
    .load_data (bus.in_data),
    .valid     (bus.out1_valid),
    .data      (bus.out1_data),
    .ready     (bus.out1_ready),
    .free      (w_free1),
    .cnt       (bus.cnt1)
  );
endmodule

// File: tb/tb_demux_1x2_stream.sv
// tb_demux_1x2_stream: directed + random checks of demux_1x2_stream against a queue scoreboard
module tb_demux_1x2_stream;
  logic clk = 1'b0;
  logic rst;
  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int n0 = 0;
  int n1 = 0;
  always #5 clk = ~clk;
  demux_1x2_stream_if #(.DW(8), .CNTW(16)) bus ();
  demux_1x2_stream_if #(.DW(8), .CNTW(4)) bus_s ();
  demux_1x2_stream #(.DW(8), .CNTW(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  demux_1x2_stream #(.DW(8), .CNTW(4)) dut_s (.clk(clk), .rst(rst), .bus(bus_s));
  assign bus_s.in_valid = bus.in_valid;
  assign bus_s.in_sel = bus.in_sel;
  assign bus_s.in_data = bus.in_data;
  assign bus_s.out0_ready = bus.out0_ready;
  assign bus_s.out1_ready = bus.out1_ready;
  always @(negedge clk) if (bus.in_valid) assert (!$isunknown(bus.in_sel)) else $error("in_sel unknown while in_valid");
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic exp_ready();
    if (rst) return 1'b0;
    return bus.in_sel ? (q1.size() == 0 || bus.out1_ready) : (q0.size() == 0 || bus.out0_ready);
  endfunction
  function automatic logic [31:0] sat(input int n, input int mx);
    return (n > mx) ? mx : n;
  endfunction
  task automatic check_all();
    chk("in_ready", bus.in_ready, exp_ready());
    chk("out0_valid", bus.out0_valid, q0.size() != 0);
    chk("out1_valid", bus.out1_valid, q1.size() != 0);
    if (q0.size() != 0) chk("out0_data", bus.out0_data, q0[0]);
    if (q1.size() != 0) chk("out1_data", bus.out1_data, q1[0]);
    chk("cnt0", bus.cnt0, sat(n0, 65535));
    chk("cnt1", bus.cnt1, sat(n1, 65535));
    chk("cnt0_small", bus_s.cnt0, sat(n0, 15));
    chk("cnt1_small", bus_s.cnt1, sat(n1, 15));
  endtask
  task automatic step();
    logic acc;
    @(negedge clk);
    check_all();
    acc = bus.in_valid && exp_ready();
    @(posedge clk);
    if (rst) begin
      q0.delete();
      q1.delete();
      n0 = 0;
      n1 = 0;
    end else begin
      if (bus.out0_ready && q0.size() != 0) begin void'(q0.pop_front()); n0++; end
      if (bus.out1_ready && q1.size() != 0) begin void'(q1.pop_front()); n1++; end
      if (acc) begin
        if (bus.in_sel) q1.push_back(bus.in_data);
        else q0.push_back(bus.in_data);
      end
    end
    #1;
  endtask
  task automatic drive(input logic v, input logic s, input logic [7:0] d, input logic r0, input logic r1);
    bus.in_valid = v;
    bus.in_sel = s;
    bus.in_data = d;
    bus.out0_ready = r0;
    bus.out1_ready = r1;
  endtask
  task automatic do_reset(input int n);
    rst = 1'b1;
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    repeat (n) step();
    rst = 1'b0;
  endtask
  initial begin
    rst = 1'b1;
    drive(1'b1, 1'b0, 8'hFF, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    repeat (2) step();
    chk("t1_in_ready", bus.in_ready, 1'b0);
    chk("t1_data0", bus.out0_data, 8'h00);
    chk("t1_data1", bus.out1_data, 8'h00);
    rst = 1'b0;
    drive(1'b1, 1'b0, 8'hA5, 1'b1, 1'b1);
    step();
    chk("t2_out0", {bus.out0_valid, bus.out0_data}, {1'b1, 8'hA5});
    drive(1'b1, 1'b1, 8'h3C, 1'b1, 1'b1);
    step();
    chk("t2_out1", {bus.out1_valid, bus.out1_data}, {1'b1, 8'h3C});
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    repeat (2) step();
    chk("t2_cnt0", bus.cnt0, 16'd1);
    chk("t2_cnt1", bus.cnt1, 16'd1);
    do_reset(1);
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, 8'(8'h40 + i), 1'b1, 1'b0);
      step();
      chk("t3_order", bus.out0_data, 8'(8'h40 + i));
    end
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    repeat (2) step();
    chk("t3_cnt0", bus.cnt0, 16'd16);
    do_reset(1);
    drive(1'b1, 1'b0, 8'h11, 1'b0, 1'b1);
    step();
    drive(1'b1, 1'b1, 8'h22, 1'b0, 1'b1);
    step();
    chk("t4_out1", {bus.out1_valid, bus.out1_data}, {1'b1, 8'h22});
    chk("t4_hold0", {bus.out0_valid, bus.out0_data}, {1'b1, 8'h11});
    drive(1'b1, 1'b0, 8'h33, 1'b0, 1'b1);
    repeat (3) step();
    chk("t4_stall", bus.in_ready, 1'b0);
    chk("t4_hold0b", bus.out0_data, 8'h11);
    drive(1'b1, 1'b0, 8'h33, 1'b1, 1'b1);
    step();
    chk("t4_out0", {bus.out0_valid, bus.out0_data}, {1'b1, 8'h33});
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    repeat (2) step();
    do_reset(1);
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b1, 8'(i * 7), 1'b1, 1'b1);
      step();
    end
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    repeat (3) step();
    chk("t5_sat", bus_s.cnt1, 32'd15);
    chk("t5_cnt1", bus.cnt1, 16'd20);
    drive(1'b1, 1'b0, 8'h44, 1'b0, 1'b0);
    step();
    drive(1'b1, 1'b1, 8'h55, 1'b0, 1'b0);
    step();
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    step();
    chk("t6_full", {bus.out0_valid, bus.out1_valid}, 2'b11);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_valids", {bus.out0_valid, bus.out1_valid}, 2'b00);
    chk("t6_cnts", {bus.cnt0, bus.cnt1}, 32'd0);
    drive(1'b1, 1'b1, 8'h66, 1'b1, 1'b1);
    step();
    chk("t6_route", {bus.out1_valid, bus.out1_data}, {1'b1, 8'h66});
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    step();
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      drive($urandom_range(0, 3) != 0, 1'($urandom), 8'($urandom), $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0 ? 1'b0 : 1'($urandom));
      step();
    end
    rst = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    repeat (3) step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
